// File: rtl/max7219_matrix_driver.sv
// Serial driver for a MAX7219-compatible 8x8 LED matrix: sends the init
// sequence after reset, then one 8-row frame per valid/ready handshake.
module max7219_matrix_driver #(
  parameter int unsigned CLK_DIV   = 2,
  parameter logic [3:0]  INTENSITY = 4'h8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] frame_data,
  input  logic        frame_valid,
  output logic        frame_ready,
  output logic        init_done,
  output logic        clk_out,
  output logic        data_out,
  output logic        load
);

  typedef enum logic [1:0] {
    INIT_SEND,
    IDLE,
    FRAME_SEND
  } state_t;

  localparam logic [7:0] TMAX       = 8'(CLK_DIV - 1);
  localparam logic [5:0] GAP_PHASE  = 6'd32;
  localparam logic [5:0] LAST_PHASE = 6'd33;

  state_t      state_q, state_d;
  logic [7:0]  timer_q, timer_d;
  logic [5:0]  phase_q, phase_d;
  logic [2:0]  word_q, word_d;
  logic [63:0] frame_q, frame_d;
  logic        init_done_q, init_done_d;
  logic        clk_out_q, clk_out_d;
  logic        data_out_q, data_out_d;
  logic        load_q, load_d;

  logic [15:0] cur_word;
  logic [3:0]  bit_idx;
  logic        phase_end;
  logic        last_word;

  always_comb begin
    cur_word = '0;
    if (state_q == INIT_SEND) begin
      case (word_q)
        3'd0:    cur_word = 16'h0C01;
        3'd1:    cur_word = 16'h0B07;
        3'd2:    cur_word = 16'h0900;
        3'd3:    cur_word = {12'h0A0, INTENSITY};
        default: cur_word = 16'h0F00;
      endcase
    end else begin
      cur_word = {4'h0, {1'b0, word_q} + 4'd1, frame_q[{word_q, 3'b000} +: 8]};
    end
  end

  assign bit_idx   = 4'd15 - phase_q[4:1];
  assign phase_end = (timer_q == TMAX);
  assign last_word = (state_q == INIT_SEND) ? (word_q == 3'd4) : (word_q == 3'd7);

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    phase_d     = phase_q;
    word_d      = word_q;
    frame_d     = frame_q;
    init_done_d = init_done_q;
    case (state_q)
      IDLE: begin
        if (frame_valid) begin
          frame_d = frame_data;
          state_d = FRAME_SEND;
          timer_d = '0;
          phase_d = '0;
          word_d  = '0;
        end
      end
      default: begin
        if (phase_end) begin
          timer_d = '0;
          if (phase_q == LAST_PHASE) begin
            phase_d = '0;
            if (last_word) begin
              word_d  = '0;
              state_d = IDLE;
              if (state_q == INIT_SEND) init_done_d = 1'b1;
            end else begin
              word_d = word_q + 3'd1;
            end
          end else begin
            phase_d = phase_q + 6'd1;
          end
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
    endcase
  end

  // Serial pins are a registered decode of the phase counters, so they trail
  // the counters by one cycle; every phase still lasts exactly CLK_DIV cycles.
  always_comb begin
    clk_out_d  = 1'b0;
    data_out_d = 1'b0;
    load_d     = 1'b1;
    if (state_q != IDLE) begin
      if (phase_q < GAP_PHASE) begin
        clk_out_d  = phase_q[0];
        data_out_d = cur_word[bit_idx];
        load_d     = 1'b0;
      end else if (phase_q == GAP_PHASE) begin
        load_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= INIT_SEND;
      timer_q     <= '0;
      phase_q     <= '0;
      word_q      <= '0;
      frame_q     <= '0;
      init_done_q <= 1'b0;
      clk_out_q   <= 1'b0;
      data_out_q  <= 1'b0;
      load_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      phase_q     <= phase_d;
      word_q      <= word_d;
      frame_q     <= frame_d;
      init_done_q <= init_done_d;
      clk_out_q   <= clk_out_d;
      data_out_q  <= data_out_d;
      load_q      <= load_d;
    end
  end

  assign frame_ready = (state_q == IDLE);
  assign init_done   = init_done_q;
  assign clk_out     = clk_out_q;
  assign data_out    = data_out_q;
  assign load        = load_q;

endmodule
